// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: multi-cycle shift-add multiplier with a start/done handshake.
// Produces the 2*WIDTH-bit product of two WIDTH-bit operands after WIDTH iterations.
// Optional feature: define MULT_SIGNED_EN for two's-complement operands (sign/magnitude
// around the same unsigned core, so latency is unchanged). Default build is unsigned.
module alu_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     src_1,
    input  logic [WIDTH-1:0]     src_2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    // Upper WIDTH+1 bits hold the partial sum with its carry; lower WIDTH bits hold
    // the not-yet-consumed multiplier bits.
    logic [2*WIDTH:0]   prod_q;

    // Operand values actually loaded into the unsigned core on acceptance.
    logic [WIDTH-1:0]   load_mcand;
    logic [WIDTH-1:0]   load_mplier;
    // One shift-add iteration of the current product register.
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   prod_step;
    logic [2*WIDTH:0]   prod_next;
    // Value written to result in DONE.
    logic [2*WIDTH-1:0] final_prod;
    logic               last_iter;

`ifdef MULT_SIGNED_EN
    logic               sign_q;
    logic               load_sign;

    // Magnitudes of both operands; -2^(WIDTH-1) maps onto itself, which is the
    // correct unsigned magnitude, so the most-negative value needs no special case.
    always_comb begin
        load_sign   = src_1[WIDTH-1] ^ src_2[WIDTH-1];
        load_mcand  = src_1[WIDTH-1] ? (WIDTH'(0) - src_1) : src_1;
        load_mplier = src_2[WIDTH-1] ? (WIDTH'(0) - src_2) : src_2;
    end

    // Re-apply the sign to the unsigned magnitude product.
    always_comb begin
        final_prod = sign_q ? ((2*WIDTH)'(0) - prod_q[2*WIDTH-1:0]) : prod_q[2*WIDTH-1:0];
    end
`else
    // Unsigned build: operands feed the core directly.
    always_comb begin
        load_mcand  = src_1;
        load_mplier = src_2;
        final_prod  = prod_q[2*WIDTH-1:0];
    end
`endif

    // Shift-add datapath: conditional add into the upper half, then shift right by one.
    always_comb begin
        upper_sum = prod_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        prod_step = prod_q[0] ? {upper_sum, prod_q[WIDTH-1:0]} : prod_q;
        prod_next = {1'b0, prod_step[2*WIDTH:1]};
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    // Control FSM with registered busy/done/result; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q <= load_mcand;
                        prod_q  <= {{(WIDTH + 1){1'b0}}, load_mplier};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
`ifdef MULT_SIGNED_EN
                        sign_q  <= load_sign;
`endif
                    end
                end
                StRun: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (last_iter) begin
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result <= final_prod;
                    done   <= 1'b1;
                    // busy is low here, so a start is accepted back-to-back.
                    if (start) begin
                        mcand_q <= load_mcand;
                        prod_q  <= {{(WIDTH + 1){1'b0}}, load_mplier};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
`ifdef MULT_SIGNED_EN
                        sign_q  <= load_sign;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Scoreboard bench for alu_seq_multiplier (WIDTH=32); honours MULT_SIGNED_EN if defined.
module tb_alu_seq_multiplier;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   src_1 = '0;
    logic [W-1:0]   src_2 = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    logic prev_done = 1'b0;

    alu_seq_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .src_1  (src_1),
        .src_2  (src_2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got result 0x%h expected no done", result);
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
        prev_done = done;
    end

    // Drive a one-cycle start at the next negedge; returns at the negedge after acceptance.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        src_1 = a;
        src_2 = b;
        @(negedge clk);
        start = 1'b0;
        src_1 = $urandom;
        src_2 = $urandom;
    endtask

    // Wait (bounded) for done; cyc counts negedges since the call.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int cyc;
        exp_q.push_back(exp);
        pulse_start(a, b);
        wait_done(name, cyc);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        logic [2*W-1:0] exp_ff;
        logic [2*W-1:0] exp_neg;

`ifdef MULT_SIGNED_EN
        exp_ff  = 64'h0000_0000_0000_0001;
        exp_neg = 64'hFFFF_FFFF_FFFF_FFF1;
`else
        exp_ff  = 64'hFFFF_FFFE_0000_0001;
        exp_neg = 64'h0000_0004_FFFF_FFF1;
`endif

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        // 2. 3*5 with busy length and latency
        exp_q.push_back(64'hF);
        pulse_start(32'd3, 32'd5);
        cyc = 1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cnt++;
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        chk("latency", 64'(cyc - 1), 64'(W + 1));
        @(negedge clk);
        chk("done_low_after", {63'd0, done}, 64'd0);

        // 3. corners
        run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_ff);
        run_op("zero", 32'h0, 32'h1234_5678, 64'h0);

        // 4a. start while busy is ignored
        exp_q.push_back(64'hF);
        pulse_start(32'd3, 32'd5);
        repeat (5) @(negedge clk);
        start = 1'b1;
        src_1 = 32'd9;
        src_2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", cyc);
        repeat (40) @(negedge clk);
        chk("ignore_no_extra", 64'(exp_q.size()), 64'd0);

        // 4b. start held through DONE: back-to-back, no idle cycle
        exp_q.push_back(64'd6);
        exp_q.push_back(64'd20);
        @(negedge clk);
        start = 1'b1;
        src_1 = 32'd2;
        src_2 = 32'd3;
        @(negedge clk);
        src_1 = 32'd4;
        src_2 = 32'd5;
        wait_done("b2b_first", cyc);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("result_stable_in_run", result, 64'd6);
        wait_done("b2b_second", cyc);
        @(negedge clk);

        // 5. reset mid-RUN discards the operation
        pulse_start(32'd3, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op("after_rst", 32'd7, 32'd6, 64'h2A);

        // 6. sign-sensitive vectors
        run_op("neg3x5", 32'hFFFF_FFFD, 32'd5, exp_neg);
        run_op("minneg", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected completion");
        $fatal(1, "watchdog");
    end

endmodule
